// File: rtl/rv32m_muldiv.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and restoring divide.
// Optional macro MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and zero-operand multiplies finish right after accept.
module rv32m_muldiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic        reg_write,
  output logic [31:0] result,
  output logic [4:0]  rd_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opb_q, opb_d;
  logic [32:0] rem_q, rem_d;
  logic        neg_q, neg_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] result_q, result_d;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    neg32 = ~x + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] x);
    neg64 = ~x + 64'd1;
  endfunction

  logic        accept;
  logic        a_sgn, b_sgn;
  logic [32:0] mul_sum;
  logic [63:0] mul_next, mul_fix;
  logic [32:0] div_shift, rem_next;
  logic [33:0] div_diff;
  logic        div_ok;
  logic [31:0] quo_next, quo_fix, rem_fix, final_res;
`ifdef MULDIV_EARLY_OUT_EN
  logic        early;
  logic [31:0] early_res;
`endif

  // Datapath step, sign correction and next-state selection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_d      = rd_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    rem_d     = rem_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    accept = start && (state_q != CALC);
    // MUL's low word is sign-agnostic, so treating it as signed is harmless.
    a_sgn  = rs1_data[31] && (funct3 != 3'd3) && (funct3 != 3'd5) && (funct3 != 3'd7);
    b_sgn  = rs2_data[31] && ((funct3 == 3'd0) || (funct3 == 3'd1) ||
                              (funct3 == 3'd4) || (funct3 == 3'd6));

    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    div_shift = {rem_q[31:0], acc_q[31]};
    div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
    div_ok    = ~div_diff[33];
    rem_next  = div_ok ? div_diff[32:0] : div_shift;
    quo_next  = {acc_q[30:0], div_ok};

    mul_fix = neg_q ? neg64(mul_next) : mul_next;
    quo_fix = neg_q ? neg32(quo_next) : quo_next;
    rem_fix = neg_rem_q ? neg32(rem_next[31:0]) : rem_next[31:0];
    case (op_q)
      3'd0:                final_res = mul_fix[31:0];
      3'd1, 3'd2, 3'd3:    final_res = mul_fix[63:32];
      3'd4, 3'd5:          final_res = quo_fix;
      default:             final_res = rem_fix;
    endcase

`ifdef MULDIV_EARLY_OUT_EN
    if (funct3[2]) begin
      early = (rs2_data == 32'd0) ||
              (!funct3[0] && (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF));
      if (rs2_data == 32'd0) begin
        early_res = funct3[1] ? rs1_data : 32'hFFFF_FFFF;
      end else begin
        early_res = funct3[1] ? 32'd0 : 32'h8000_0000;
      end
    end else begin
      early     = (rs1_data == 32'd0) || (rs2_data == 32'd0);
      early_res = 32'd0;
    end
`endif

    case (state_q)
      CALC: begin
        cnt_d = cnt_q + 5'd1;
        if (op_q[2]) begin
          acc_d = {32'd0, quo_next};
          rem_d = rem_next;
        end else begin
          acc_d = mul_next;
        end
        if (cnt_q == 5'd31) begin
          result_d = final_res;
          state_d  = DONE;
        end else begin
          state_d  = CALC;
        end
      end
      IDLE, DONE: begin
        if (accept) begin
          op_d      = funct3;
          rd_d      = rd_in;
          cnt_d     = 5'd0;
          rem_d     = 33'd0;
          acc_d     = {32'd0, a_sgn ? neg32(rs1_data) : rs1_data};
          opb_d     = b_sgn ? neg32(rs2_data) : rs2_data;
          // Division by zero keeps the all-ones quotient unsigned.
          neg_d     = (a_sgn ^ b_sgn) && !(funct3[2] && (rs2_data == 32'd0));
          neg_rem_d = a_sgn;
`ifdef MULDIV_EARLY_OUT_EN
          if (early) begin
            result_d = early_res;
            state_d  = DONE;
          end else begin
            state_d  = CALC;
          end
`else
          state_d   = CALC;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      op_q      <= 3'd0;
      rd_q      <= 5'd0;
      acc_q     <= 64'd0;
      opb_q     <= 32'd0;
      rem_q     <= 33'd0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      rem_q     <= rem_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign busy      = (state_q == CALC);
  assign done      = (state_q == DONE);
  assign reg_write = (state_q == DONE);
  assign result    = result_q;
  assign rd_out    = rd_q;

endmodule
